// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the EX stage.
// Produces {remainder, quotient} for DIV/DIVU and stalls F/D/E while busy.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   alucontrolE  EX-stage op code; EXE_DIV_OP / EXE_DIVU_OP start the unit
//   srcaE        dividend (rs)
//   srcbE        divisor (rt)
//   advanceE     EX instruction leaves EX this cycle
//   flushE       EX instruction cancelled
//   div_stall    combinational stall request for F/D/E
//   div_ready    div_result valid for the current EX instruction
//   div_result   {remainder, quotient}
//
// Build option: define DIV_ZERO_FAST_EN to finish a zero-divisor op in one
// cycle instead of running the full iteration count.
module div_unit #(
    parameter int         WIDTH       = 32,
    parameter int         CNT_W       = 6,
    parameter logic [7:0] EXE_DIV_OP  = 8'b0001_1010,
    parameter logic [7:0] EXE_DIVU_OP = 8'b0001_1011
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         alucontrolE,
    input  logic [WIDTH-1:0]   srcaE,
    input  logic [WIDTH-1:0]   srcbE,
    input  logic               advanceE,
    input  logic               flushE,
    output logic               div_stall,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] div_result
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             sgn;
    logic             sign_q;
    logic             sign_r;
    logic             dvs_zero;

    logic             is_div;
    logic             is_signed;
    logic             start;
    logic             step;
    logic             fast_done;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] dvd_n;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [2*WIDTH-1:0] res_n;
    logic [2*WIDTH-1:0] zero_res;

    assign is_div    = (alucontrolE == EXE_DIV_OP) |
                       (alucontrolE == EXE_DIVU_OP);
    assign is_signed = (alucontrolE == EXE_DIV_OP);

    // Gated by reset so every output reads 0 while reset is held.
    assign div_stall = rst & is_div & ~flushE & (state != DONE);
    assign div_ready = (state == DONE);

    assign start     = (state == IDLE) & is_div & ~flushE;
    assign step      = (state == BUSY) & is_div & ~flushE;
    assign fast_done = FAST_ZERO & (srcbE == '0);

    assign a_abs = (is_signed & srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign b_abs = (is_signed & srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // One restoring step: the partial remainder needs one extra bit
    // after the shift before it is compared against the divisor.
    assign rem_sh  = {rem, dvd[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dvs};
    assign ge      = (rem_sh >= {1'b0, dvs});
    assign rem_n   = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign dvd_n   = {dvd[WIDTH-2:0], ge};

    assign q_fix = (sgn & sign_q) ? -dvd_n : dvd_n;
    assign r_fix = (sgn & sign_r) ? -rem_n : rem_n;

    assign zero_res = {a_raw, {WIDTH{1'b1}}};
    assign res_n    = dvs_zero ? zero_res : {r_fix, q_fix};

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = fast_done ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flushE | ~is_div) begin
                    state_n = IDLE;
                end else if (cnt == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (flushE | advanceE) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            a_raw      <= '0;
            sgn        <= 1'b0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            dvs_zero   <= 1'b0;
            div_result <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                dvd      <= a_abs;
                dvs      <= b_abs;
                a_raw    <= srcaE;
                sgn      <= is_signed;
                sign_q   <= srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
                sign_r   <= srcaE[WIDTH-1];
                dvs_zero <= (srcbE == '0);
                rem      <= '0;
                cnt      <= '0;
                if (fast_done) begin
                    div_result <= {srcaE, {WIDTH{1'b1}}};
                end
            end else if (step) begin
                rem <= rem_n;
                dvd <= dvd_n;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    div_result <= res_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed bench for div_unit, checked every
// cycle against an arithmetic reference model of the divider.
module tb_div_unit;

    localparam int         W    = 32;
    localparam logic [7:0] DIV  = 8'b0001_1010;
    localparam logic [7:0] DIVU = 8'b0001_1011;
    localparam logic [7:0] NOP  = 8'h00;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic [7:0]    alu    = NOP;
    logic [W-1:0]  a      = '0;
    logic [W-1:0]  b      = '0;
    logic          adv_en = 1'b1;
    logic          flush  = 1'b0;
    logic          advance;
    logic          stall;
    logic          ready;
    logic [2*W-1:0] res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign advance = ~stall & adv_en;

    div_unit #(
        .WIDTH       (W),
        .CNT_W       (6),
        .EXE_DIV_OP  (DIV),
        .EXE_DIVU_OP (DIVU)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alucontrolE (alu),
        .srcaE       (a),
        .srcbE       (b),
        .advanceE    (advance),
        .flushE      (flush),
        .div_stall   (stall),
        .div_ready   (ready),
        .div_result  (res)
    );

    function automatic logic [2*W-1:0] ref_div(input logic [7:0] op,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint sx, sy, q, r;
        if (y == '0) return {x, 32'hFFFF_FFFF};
        if (op == DIVU) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: cycles remaining until the result is due.
    logic           m_is;
    bit             mbusy = 1'b0;
    bit             mdone = 1'b0;
    int             mleft = 0;
    logic [2*W-1:0] mres  = '0;
    logic [2*W-1:0] mpend = '0;

    assign m_is = (alu == DIV) || (alu == DIVU);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mbusy <= 1'b0;
            mdone <= 1'b0;
            mleft <= 0;
            mres  <= '0;
        end else if (flush) begin
            mbusy <= 1'b0;
            mdone <= 1'b0;
        end else if (mdone) begin
            if (advance) mdone <= 1'b0;
        end else if (mbusy) begin
            if (!m_is) begin
                mbusy <= 1'b0;
            end else begin
                mleft <= mleft - 1;
                if (mleft == 1) begin
                    mbusy <= 1'b0;
                    mdone <= 1'b1;
                    mres  <= mpend;
                end
            end
        end else if (m_is) begin
            if (FAST && b == '0) begin
                mdone <= 1'b1;
                mres  <= ref_div(alu, a, b);
            end else begin
                mbusy <= 1'b1;
                mleft <= W;
                mpend <= ref_div(alu, a, b);
            end
        end
    end

    always @(negedge clk) begin
        chk("stall", 64'(stall), 64'(rst && m_is && !flush && !mdone));
        chk("ready", 64'(ready), 64'(mdone));
        chk("result", res, mres);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue at posedge+1, wait for ready, hold DONE for 'hold' cycles,
    // then leave DONE. Returns the first ready result and stall count.
    task automatic run(input logic [7:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int hold,
                       output logic [2*W-1:0] r, output int sc);
        bit ok;
        alu = op;
        a   = x;
        b   = y;
        sc  = 0;
        ok  = 1'b0;
        r   = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (stall) sc++;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("timeout", 64'(ok), 64'd1);
        r = res;
        if (hold > 0) begin
            adv_en = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_ready", 64'(ready), 64'd1);
                chk("hold_res", res, r);
            end
            adv_en = 1'b1;
        end
        step();
        alu = NOP;
    endtask

    logic [2*W-1:0] r;
    int             sc;
    int             exp_lat;

    initial begin
        exp_lat = FAST ? 1 : 33;
        step();
        step();
        chk("rst_res", res, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        rst = 1'b1;
        step();

        run(DIVU, 32'd100, 32'd7, 0, r, sc);
        chk("t1_res", r, {32'd2, 32'd14});
        chk("t1_lat", 64'(sc), 64'd33);
        @(negedge clk);
        chk("t1_ready_drop", 64'(ready), 64'd0);
        step();

        run(DIV, -32'sd7, 32'd2, 0, r, sc);
        chk("t2_neg", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, sc);
        chk("t2_ovf", r, {32'd0, 32'h8000_0000});

        run(DIV, 32'd5, 32'd0, 0, r, sc);
        chk("t3_zero", r, {32'd5, 32'hFFFF_FFFF});
        chk("t3_lat", 64'(sc), 64'(exp_lat));
        run(DIVU, 32'd5, 32'd0, 0, r, sc);
        chk("t3_zero_u", r, {32'd5, 32'hFFFF_FFFF});

        run(DIVU, 32'd1000, 32'd10, 4, r, sc);
        chk("t4_res", r, {32'd0, 32'd100});
        @(negedge clk);
        chk("t4_idle", 64'(ready), 64'd0);
        step();

        alu = DIV;
        a   = 32'd1000;
        b   = 32'd3;
        for (int i = 0; i < 10; i++) @(negedge clk);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        alu   = NOP;
        @(negedge clk);
        chk("t5_stall", 64'(stall), 64'd0);
        chk("t5_ready", 64'(ready), 64'd0);
        chk("t5_keep", res, {32'd0, 32'd100});
        step();
        run(DIVU, 32'd9, 32'd3, 0, r, sc);
        chk("t5_res", r, {32'd0, 32'd3});

        alu = DIVU;
        a   = 32'd77;
        b   = 32'd5;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_stall", 64'(stall), 64'd0);
        chk("t6_ready", 64'(ready), 64'd0);
        chk("t6_res", res, 64'd0);
        step();
        alu = NOP;
        rst = 1'b1;
        step();
        run(DIVU, 32'd1, 32'd1, 0, r, sc);
        chk("t6_after", r, {32'd0, 32'd1});

        for (int n = 0; n < 30; n++) begin
            logic [7:0]   op;
            logic [W-1:0] x, y;
            int           sel;
            op  = $urandom_range(0, 1) ? DIV : DIVU;
            x   = $urandom;
            sel = $urandom_range(0, 7);
            unique case (sel)
                0, 1:    y = '0;
                2, 3:    y = W'($urandom_range(1, 15));
                4:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) begin
                alu = op;
                a   = x;
                b   = y;
                for (int k = 0; k < $urandom_range(0, 20); k++) step();
                flush = 1'b1;
                step();
                flush = 1'b0;
                alu   = NOP;
            end else begin
                run(op, x, y, $urandom_range(0, 3), r, sc);
                chk("rnd_res", r, ref_div(op, x, y));
            end
            for (int k = 0; k < $urandom_range(0, 2); k++) step();
        end

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
